// File: rtl/bus_ctrl_6502.sv
// Address decoder, wait-state generator and read-data mux between the 6502 core
// and NREG memory/peripheral regions, with sticky capture of unmapped accesses.
module bus_ctrl_6502 #(
  parameter int                        NREG      = 3,
  parameter int                        PAGE_BITS = 4,
  parameter logic [NREG*PAGE_BITS-1:0] BASE      = {4'hF, 4'h1, 4'h0},
  parameter logic [NREG*4-1:0]         WAIT      = {4'd0, 4'd0, 4'd2},
  parameter logic [7:0]                UNMAP_VAL = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cpu_ab,
  input  logic [7:0]        cpu_do,
  input  logic              cpu_we,
  output logic              cpu_rdy,
  output logic [7:0]        cpu_di,
  output logic [NREG-1:0]   reg_cs,
  output logic [NREG-1:0]   reg_wstb,
  output logic [15:0]       reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [NREG*8-1:0] reg_rdata,
  input  logic              err_clr,
  output logic              err_flag,
  output logic [15:0]       err_addr
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] widx_q, widx_d;
  logic [IW-1:0] sel_idx_q;
  logic          sel_unmap_q;
  logic          err_flag_q;
  logic [15:0]   err_addr_q;

  logic          hit_any;
  logic [IW-1:0] hit_idx;
  logic [3:0]    hit_wait;
  logic [IW-1:0] cur_idx;
  logic          cur_map;

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (cpu_ab[15 -: PAGE_BITS] == BASE[i*PAGE_BITS +: PAGE_BITS]) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    reg_cs = '0;
    if (hit_any) reg_cs[hit_idx] = 1'b1;
  end

  assign hit_wait = WAIT[{hit_idx, 2'b00} +: 4];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    cpu_rdy = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (hit_any && hit_wait != 4'd0) begin
          cpu_rdy = 1'b0;
          state_d = S_WAIT;
          cnt_d   = hit_wait - 4'd1;
          widx_d  = hit_idx;
        end
      end
      S_WAIT: begin
        cpu_rdy = (cnt_q == 4'd0);
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A waited access completes on its latched region, regardless of cpu_ab.
  assign cur_idx = (state_q == S_WAIT) ? widx_q : hit_idx;
  assign cur_map = (state_q == S_WAIT) | hit_any;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      widx_q      <= '0;
      sel_idx_q   <= '0;
      sel_unmap_q <= 1'b1;
      err_flag_q  <= 1'b0;
      err_addr_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      if (cpu_rdy) begin
        sel_idx_q   <= cur_idx;
        sel_unmap_q <= ~cur_map;
      end
      // A new error beats a coincident clear; otherwise the first error is kept.
      if (cpu_rdy && !cur_map) begin
        if (!err_flag_q || err_clr) begin
          err_flag_q <= 1'b1;
          err_addr_q <= cpu_ab;
        end
      end else if (err_clr) begin
        err_flag_q <= 1'b0;
      end
    end
  end

  assign cpu_di    = sel_unmap_q ? UNMAP_VAL : reg_rdata[{sel_idx_q, 3'b000} +: 8];
  assign reg_wstb  = reg_cs & {NREG{cpu_we & cpu_rdy}};
  assign reg_addr  = cpu_ab;
  assign reg_wdata = cpu_do;
  assign err_flag  = err_flag_q;
  assign err_addr  = err_addr_q;

endmodule
